ram_port1_rd_arbiter: RTL and testbench

- Shares the single read-only port 1 of the dual-port SRAM (csb1/addr1/dout1) among NUM_REQ requesters.
- Requesters issue burst read requests: a start address and a beat count.
- The block grants requesters round-robin, sequences consecutive addresses onto port 1, and routes returned data to the granted requester.
- It sits between the SRAM macro's port-1 pins and the read clients, in the clk1 domain.

---
 rtl/ram_port1_rd_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_port1_rd_arbiter.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port1_rd_arbiter.sv
// ram_port1_rd_arbiter
// Shares the read-only port 1 of a dual-port SRAM among NUM_REQ burst-read
// requesters. It grants requesters round-robin, sequences consecutive word
// addresses onto csb1/addr1, and routes the returned dout1 words back to
// the granted requester through a READ_LATENCY-deep tag pipeline.
// Everything runs in the clk1 domain. Reset is synchronous and active high.
// ADDR_WIDTH and DATA_WIDTH default to 8/32. Override them at instantiation
// with the project-wide SRAM widths.

module ram_port1_rd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                            clk1,
    input  logic                            rst1,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_last,
    output logic                            busy,
    output logic                            csb1,
    output logic [ADDR_WIDTH-1:0]           addr1,
    input  logic [DATA_WIDTH-1:0]           dout1
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // One entry per issued read. When the entry leaves the pipeline it
    // tells the response side who owns the dout1 word and whether it is
    // the final beat of the burst.
    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] gnt;
        logic             last;
    } tag_t;

    state_t               state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     gnt;
    logic [LEN_WIDTH-1:0] cnt;
    logic [PTR_W-1:0]     win;
    logic                 found;

    tag_t                 tag_pipe [READ_LATENCY];
    tag_t                 tag_in;
    tag_t                 tag_out;
    logic                 pipe_busy;

    // Round-robin search: the first valid requester at or after rr_ptr wins.
    // NOTE: every variable gets a default before the loop. Each path then
    // assigns it, so no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // The grant is offered combinationally, and only while IDLE.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) begin
            req_ready[win] = 1'b1;
        end
    end

    // Burst sequencer: accept in IDLE, then issue one beat per cycle in BURST.
    // NOTE: all registered state uses non-blocking assignments. Every flop
    // therefore sees pre-edge values, whatever order the statements run in.
    always_ff @(posedge clk1) begin
        if (rst1) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            gnt    <= '0;
            csb1   <= 1'b1;
            addr1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        csb1   <= 1'b0;
                        addr1  <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                        cnt    <= req_len[win*LEN_WIDTH +: LEN_WIDTH];
                        gnt    <= win;
                        rr_ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        state  <= BURST;
                    end
                end
                BURST: begin
                    if (cnt != '0) begin
                        addr1 <= addr1 + 1'b1;
                        cnt   <= cnt - 1'b1;
                    end else begin
                        csb1  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    csb1  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tag for the beat on the port this cycle. Idle cycles push an empty tag.
    always_comb begin
        tag_in = '0;
        if (!csb1) begin
            tag_in.valid = 1'b1;
            tag_in.gnt   = gnt;
            tag_in.last  = (cnt == '0);
        end
    end

    // Delays each tag by READ_LATENCY cycles so it lines up with its dout1 word.
    // NOTE: unlike a data array, this shift register is reset. Its valid bits
    // drive rsp_valid and busy directly, so a reset must discard in-flight reads.
    always_ff @(posedge clk1) begin
        if (rst1) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out = tag_pipe[READ_LATENCY-1];

    // Route the returning word to its owner. The data path is a pass-through
    // of dout1, held at zero while no beat is returning.
    always_comb begin
        rsp_valid = '0;
        rsp_last  = 1'b0;
        rsp_data  = '0;
        if (tag_out.valid) begin
            rsp_valid[tag_out.gnt] = 1'b1;
            rsp_last               = tag_out.last;
            rsp_data               = dout1;
        end
    end

    // busy covers the burst itself and every read still in flight.
    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            if (tag_pipe[i].valid) begin
                pipe_busy = 1'b1;
            end
        end
    end

    assign busy = (state == BURST) | pipe_busy;

endmodule

// File: tb/tb_ram_port1_rd_arbiter.sv
// tb_ram_port1_rd_arbiter
// Two instances share one set of request inputs: u_l1 with READ_LATENCY=1
// and u_l3 with READ_LATENCY=3. Each instance has a behavioural SRAM with a
// matching read delay. The reference model is a schedule indexed by cycle.
// Each accept books its beats as (cycle -> address, owner, last) records.
// A beat returns exactly `latency` cycles after its issue cycle. A reset
// drops every record from before it.

module tb_ram_port1_rd_arbiter;

    localparam int N    = 4;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int LW   = 4;
    localparam int MAXC = 4096;

    logic            clk1 = 1'b0;
    logic            rst1;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;

    logic [N-1:0]    ready_o [2];
    logic [N-1:0]    rv_o    [2];
    logic [DW-1:0]   rd_o    [2];
    logic            last_o  [2];
    logic            busy_o  [2];
    logic            csb_o   [2];
    logic [AW-1:0]   addr_o  [2];
    logic [DW-1:0]   dout    [2];

    logic [DW-1:0]   mem [256];
    logic [DW-1:0]   d1;
    logic [DW-1:0]   d3 [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference schedule
    bit            rec_v [MAXC];
    logic [AW-1:0] rec_a [MAXC];
    int            rec_g [MAXC];
    bit            rec_l [MAXC];
    int            mptr   = 0;
    int            rbound = 0;
    bit            mon_on = 1'b0;

    ram_port1_rd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                           .LEN_WIDTH(LW), .READ_LATENCY(1)) u_l1 (
        .clk1(clk1), .rst1(rst1), .req_valid(req_valid), .req_ready(ready_o[0]),
        .req_addr(req_addr), .req_len(req_len), .rsp_valid(rv_o[0]),
        .rsp_data(rd_o[0]), .rsp_last(last_o[0]), .busy(busy_o[0]),
        .csb1(csb_o[0]), .addr1(addr_o[0]), .dout1(dout[0]));

    ram_port1_rd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                           .LEN_WIDTH(LW), .READ_LATENCY(3)) u_l3 (
        .clk1(clk1), .rst1(rst1), .req_valid(req_valid), .req_ready(ready_o[1]),
        .req_addr(req_addr), .req_len(req_len), .rsp_valid(rv_o[1]),
        .rsp_data(rd_o[1]), .rsp_last(last_o[1]), .busy(busy_o[1]),
        .csb1(csb_o[1]), .addr1(addr_o[1]), .dout1(dout[1]));

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    // Behavioural SRAMs. A cycle with no read returns junk, so any response
    // claimed on such a word shows up as a data mismatch.
    always @(posedge clk1) begin
        d1    <= !csb_o[0] ? mem[addr_o[0]] : DW'($urandom);
        d3[0] <= !csb_o[1] ? mem[addr_o[1]] : DW'($urandom);
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign dout[0] = d1;
    assign dout[1] = d3[2];

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Per-cycle scoreboard: compares both instances against the schedule,
    // then books new accepts or applies a reset.
    always @(negedge clk1) begin
        if (mon_on) begin
            int c, w, s, ln;
            logic [N-1:0] er, erv;
            logic [AW-1:0] a;
            bit ev, eb;
            c = cyc;
            w = -1;
            if (!rec_v[c]) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
                end
            end
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (ready_o[i] !== er) begin
                    bad++;
                    $display("FAIL mon_ready inst%0d cyc=%0d got=%b want=%b", i, c, ready_o[i], er);
                end
                total++;
                if (csb_o[i] !== !rec_v[c]) begin
                    bad++;
                    $display("FAIL mon_csb1 inst%0d cyc=%0d got=%b want=%b", i, c, csb_o[i], !rec_v[c]);
                end
                if (rec_v[c]) begin
                    total++;
                    if (addr_o[i] !== rec_a[c]) begin
                        bad++;
                        $display("FAIL mon_addr1 inst%0d cyc=%0d got=%h want=%h", i, c, addr_o[i], rec_a[c]);
                    end
                end
                s   = c - lat(i);
                ev  = (s >= 0) && (s >= rbound) && rec_v[s];
                erv = '0;
                if (ev) erv[rec_g[s]] = 1'b1;
                total++;
                if (rv_o[i] !== erv) begin
                    bad++;
                    $display("FAIL mon_rsp_valid inst%0d cyc=%0d got=%b want=%b", i, c, rv_o[i], erv);
                end
                total++;
                if (last_o[i] !== (ev && rec_l[s])) begin
                    bad++;
                    $display("FAIL mon_rsp_last inst%0d cyc=%0d got=%b want=%b", i, c, last_o[i], ev && rec_l[s]);
                end
                if (ev) begin
                    total++;
                    if (rd_o[i] !== mem[rec_a[s]]) begin
                        bad++;
                        $display("FAIL mon_rsp_data inst%0d cyc=%0d got=%h want=%h", i, c, rd_o[i], mem[rec_a[s]]);
                    end
                end
                eb = 1'b0;
                for (int s2 = c - lat(i); s2 <= c; s2++) begin
                    if (s2 >= 0 && s2 >= rbound && rec_v[s2]) eb = 1'b1;
                end
                total++;
                if (busy_o[i] !== eb) begin
                    bad++;
                    $display("FAIL mon_busy inst%0d cyc=%0d got=%b want=%b", i, c, busy_o[i], eb);
                end
            end
            if (rst1) begin
                for (int j = c + 1; j < c + 24; j++) rec_v[j] = 1'b0;
                mptr   = 0;
                rbound = c + 1;
            end else if (w >= 0) begin
                ln = int'(req_len[w*LW +: LW]);
                a  = req_addr[w*AW +: AW];
                for (int j = 0; j <= ln; j++) begin
                    rec_v[c+1+j] = 1'b1;
                    rec_a[c+1+j] = AW'(int'(a) + j);
                    rec_g[c+1+j] = w;
                    rec_l[c+1+j] = (j == ln);
                end
                mptr = (w + 1) % N;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) next_cycle();
    endtask

    task automatic test_reset();
        rst1      = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (csb_o[i] !== 1'b1 || addr_o[i] !== '0 || ready_o[i] !== '0) begin
                bad++;
                $display("FAIL reset_port inst%0d got csb=%b addr=%h ready=%b want 1/00/0000",
                         i, csb_o[i], addr_o[i], ready_o[i]);
            end
            total++;
            if (rv_o[i] !== '0 || last_o[i] !== 1'b0 || rd_o[i] !== '0 || busy_o[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_rsp inst%0d got valid=%b last=%b data=%h busy=%b want all zero",
                         i, rv_o[i], last_o[i], rd_o[i], busy_o[i]);
            end
        end
        next_cycle();
        rst1   = 1'b0;
        mptr   = 0;
        rbound = cyc;
        mon_on = 1'b1;
    endtask

    task automatic test_single();
        next_cycle();
        req_valid          = 4'b0010;
        req_addr[1*AW +: AW] = 8'h10;
        req_len[1*LW +: LW]  = 4'd0;
        @(negedge clk1);
        total++;
        if (ready_o[0] !== 4'b0010) begin
            bad++;
            $display("FAIL single_ready got=%b want=0010", ready_o[0]);
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk1);
        total++;
        if (csb_o[0] !== 1'b0 || addr_o[0] !== 8'h10) begin
            bad++;
            $display("FAIL single_issue got csb=%b addr=%h want 0/10", csb_o[0], addr_o[0]);
        end
        next_cycle();
        @(negedge clk1);
        total++;
        if (csb_o[0] !== 1'b1 || rv_o[0] !== 4'b0010 || last_o[0] !== 1'b1 || rd_o[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_rsp got csb=%b valid=%b last=%b data=%h want 1/0010/1/deadbeef",
                     csb_o[0], rv_o[0], last_o[0], rd_o[0]);
        end
        idle(3);
    endtask

    task automatic test_burst();
        req_valid          = 4'b0001;
        req_addr[0 +: AW]  = 8'h20;
        req_len[0 +: LW]   = 4'd3;
        @(negedge clk1);
        total++;
        if (ready_o[0] !== 4'b0001) begin
            bad++;
            $display("FAIL burst_ready got=%b want=0001", ready_o[0]);
        end
        for (int d = 1; d <= 6; d++) begin
            next_cycle();
            req_valid = '0;
            @(negedge clk1);
            if (d <= 4) begin
                total++;
                if (csb_o[0] !== 1'b0 || addr_o[0] !== AW'(8'h20 + d - 1)) begin
                    bad++;
                    $display("FAIL burst_issue beat%0d got csb=%b addr=%h want 0/%h",
                             d, csb_o[0], addr_o[0], AW'(8'h20 + d - 1));
                end
            end
            if (d >= 2 && d <= 5) begin
                total++;
                if (rv_o[0] !== 4'b0001 || rd_o[0] !== mem[8'h20 + d - 2] || last_o[0] !== (d == 5)) begin
                    bad++;
                    $display("FAIL burst_rsp beat%0d got valid=%b data=%h last=%b want 0001/%h/%b",
                             d - 1, rv_o[0], rd_o[0], last_o[0], mem[8'h20 + d - 2], d == 5);
                end
            end
            if (d >= 5) begin
                total++;
                if (busy_o[0] !== (d == 5)) begin
                    bad++;
                    $display("FAIL burst_busy d=%0d got=%b want=%b", d, busy_o[0], d == 5);
                end
            end
        end
        idle(2);
    endtask

    // With every requester holding a single-beat request, a grant is offered
    // in every IDLE cycle. Consecutive grants are therefore two cycles apart:
    // the issue cycle, then the one idle cycle in which the next grant is made.
    task automatic test_round_robin();
        int order [5];
        int when  [5];
        int n = 0;
        rst1      = 1'b1;
        req_valid = 4'b1111;
        req_len   = '0;
        req_addr  = {$urandom};
        next_cycle();
        rst1 = 1'b0;
        for (int t = 0; t < 20 && n < 5; t++) begin
            @(negedge clk1);
            for (int b = 0; b < N; b++) begin
                if (ready_o[0][b]) begin
                    order[n] = b;
                    when[n]  = cyc;
                    n++;
                end
            end
            next_cycle();
            if (n == 5) req_valid = '0;
        end
        req_valid = '0;
        total++;
        if (n != 5) begin
            bad++;
            $display("FAIL rr_count got=%0d grants want=5", n);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (order[i] != i % N) begin
                    bad++;
                    $display("FAIL rr_order grant%0d got=%0d want=%0d", i, order[i], i % N);
                end
                if (i > 0) begin
                    total++;
                    if (when[i] - when[i-1] != 2) begin
                        bad++;
                        $display("FAIL rr_spacing grant%0d got=%0d want=2", i, when[i] - when[i-1]);
                    end
                end
            end
        end
        idle(3);
    endtask

    task automatic test_wrap();
        req_valid            = 4'b1000;
        req_addr[3*AW +: AW] = 8'hFE;
        req_len[3*LW +: LW]  = 4'd2;
        @(negedge clk1);
        total++;
        if (ready_o[0] !== 4'b1000) begin
            bad++;
            $display("FAIL wrap_ready got=%b want=1000", ready_o[0]);
        end
        for (int d = 1; d <= 4; d++) begin
            logic [AW-1:0] ea, ra;
            ea = AW'(8'hFE + d - 1);
            ra = AW'(8'hFE + d - 2);
            next_cycle();
            req_valid = '0;
            @(negedge clk1);
            if (d <= 3) begin
                total++;
                if (addr_o[0] !== ea) begin
                    bad++;
                    $display("FAIL wrap_addr beat%0d got=%h want=%h", d, addr_o[0], ea);
                end
            end
            if (d >= 2) begin
                total++;
                if (rv_o[0] !== 4'b1000 || rd_o[0] !== mem[ra]) begin
                    bad++;
                    $display("FAIL wrap_rsp beat%0d got valid=%b data=%h want 1000/%h",
                             d - 1, rv_o[0], rd_o[0], mem[ra]);
                end
            end
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        req_valid            = 4'b0100;
        req_addr[2*AW +: AW] = AW'($urandom);
        req_len[2*LW +: LW]  = 4'd7;
        @(negedge clk1);
        total++;
        if (ready_o[0] !== 4'b0100) begin
            bad++;
            $display("FAIL rstmid_ready got=%b want=0100", ready_o[0]);
        end
        repeat (3) begin
            next_cycle();
            req_valid = '0;
        end
        next_cycle();
        rst1 = 1'b1;
        next_cycle();
        rst1 = 1'b0;
        @(negedge clk1);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (csb_o[i] !== 1'b1 || addr_o[i] !== '0 || rv_o[i] !== '0 || busy_o[i] !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_state inst%0d got csb=%b addr=%h valid=%b busy=%b want 1/00/0000/0",
                         i, csb_o[i], addr_o[i], rv_o[i], busy_o[i]);
            end
        end
        idle(6);
        req_valid            = 4'b1010;
        req_addr[1*AW +: AW] = AW'($urandom);
        req_addr[3*AW +: AW] = AW'($urandom);
        req_len              = '0;
        @(negedge clk1);
        total++;
        if (ready_o[0] !== 4'b0010) begin
            bad++;
            $display("FAIL rstmid_ptr got=%b want=0010", ready_o[0]);
        end
        idle(6);
    endtask

    task automatic test_latency3();
        logic [AW-1:0] a;
        a                 = AW'($urandom);
        req_valid         = 4'b0001;
        req_addr[0 +: AW] = a;
        req_len[0 +: LW]  = 4'd1;
        for (int d = 0; d <= 6; d++) begin
            logic [N-1:0] ev;
            logic [AW-1:0] ra;
            ra = AW'(int'(a) + d - 4);
            ev = (d == 4 || d == 5) ? 4'b0001 : 4'b0000;
            @(negedge clk1);
            if (d >= 1) begin
                total++;
                if (rv_o[1] !== ev) begin
                    bad++;
                    $display("FAIL lat3_valid d=%0d got=%b want=%b", d, rv_o[1], ev);
                end
            end
            if (d == 4 || d == 5) begin
                total++;
                if (rd_o[1] !== mem[ra] || last_o[1] !== (d == 5)) begin
                    bad++;
                    $display("FAIL lat3_rsp d=%0d got data=%h last=%b want %h/%b",
                             d, rd_o[1], last_o[1], mem[ra], d == 5);
                end
            end
            next_cycle();
            req_valid = '0;
        end
        idle(3);
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            req_valid = N'($urandom);
            req_addr  = {$urandom};
            req_len   = (N*LW)'($urandom);
            rst1      = ($urandom_range(0, 63) == 0);
            next_cycle();
        end
        rst1 = 1'b0;
        idle(10);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h10] = 32'hDEADBEEF;
        test_reset();
        test_single();
        test_burst();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_latency3();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
